// File: rtl/seg7_signed_display_mux_pkg.sv
// Shared segment codes, BCD-to-segment decode and display FSM state type
// for the signed multi-digit 7-segment driver.
package seg7_pkg;

    // Segment order {g,f,e,d,c,b,a}, active low
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } disp_state_t;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    bcd_to_seg = SEG_0;
            4'd1:    bcd_to_seg = SEG_1;
            4'd2:    bcd_to_seg = SEG_2;
            4'd3:    bcd_to_seg = SEG_3;
            4'd4:    bcd_to_seg = SEG_4;
            4'd5:    bcd_to_seg = SEG_5;
            4'd6:    bcd_to_seg = SEG_6;
            4'd7:    bcd_to_seg = SEG_7;
            4'd8:    bcd_to_seg = SEG_8;
            4'd9:    bcd_to_seg = SEG_9;
            default: bcd_to_seg = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg7_signed_display_mux_if.sv
// Value-load and display-drive bundle for seg7_signed_display_mux.
interface seg7_signed_display_mux_if #(
    parameter int DATA_W = 8,
    parameter int DIGITS = 4
);
    logic              load;
    logic [DATA_W-1:0] value;
    logic              busy;
    logic              overflow;
    logic [DIGITS-1:0] an;
    logic [6:0]        seg;

    modport master (output load, value, input busy, overflow, an, seg);
    modport slave  (input load, value, output busy, overflow, an, seg);
endinterface

// File: rtl/seg7_signed_display_mux_bin2bcd.sv
// Sequential double-dabble converter: one add-3/shift step per clock,
// DATA_W steps after start.
module bin2bcd_seq #(
    parameter int DATA_W     = 8,
    parameter int BCD_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_W-1:0]       mag,
    output logic                    busy,
    output logic                    done,
    output logic [BCD_DIGITS*4-1:0] bcd
);
    localparam int CW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0]       shreg;
    logic [CW-1:0]           cnt;
    logic [BCD_DIGITS*4-1:0] adj;

    always_comb begin
        adj = bcd;
        for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
    end

    assign busy = (cnt != '0);
    // done marks the cycle whose clock edge performs the final step
    assign done = (cnt == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
            bcd   <= '0;
        end else if (start) begin
            shreg <= mag;
            cnt   <= CW'(DATA_W);
            bcd   <= '0;
        end else if (busy) begin
            bcd   <= {adj[BCD_DIGITS*4-2:0], shreg[DATA_W-1]};
            shreg <= shreg << 1;
            cnt   <= cnt - CW'(1);
        end
    end
endmodule

// File: rtl/seg7_signed_display_mux.sv
// Multi-digit 7-segment driver: captures a signed/unsigned value, converts it
// to BCD, and time-multiplexes blanked/signed digits onto one segment bus.
module seg7_signed_display_mux
    import seg7_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int DIGITS      = 4,
    parameter int SIGNED      = 1,
    parameter int REFRESH_DIV = 100000
) (
    input logic                     clk,
    input logic                     rst,
    seg7_signed_display_mux_if.slave disp
);
    localparam int          BCD_DIGITS = (DATA_W * 3) / 10 + 1;
    localparam int          EXT        = (DIGITS > BCD_DIGITS) ? DIGITS : BCD_DIGITS;
    localparam int          CW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int          IW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned DIGITS_U   = DIGITS;
    localparam int unsigned BCD_U      = BCD_DIGITS;

    disp_state_t             state;
    logic                    sign_q;
    logic                    neg;
    logic [DATA_W-1:0]       mag;
    logic                    start;
    logic                    conv_busy;
    logic                    conv_done;
    logic [BCD_DIGITS*4-1:0] bcd;
    logic [EXT*4-1:0]        bcd_ext;
    logic [6:0]              next_seg [DIGITS];
    logic [6:0]              disp_seg [DIGITS];
    logic                    next_ovf;
    logic                    ovf_q;
    int unsigned             nd;
    int unsigned             need;
    logic [CW-1:0]           rcnt;
    logic [IW-1:0]           idx;

    // Two's-complement negate in DATA_W bits: read unsigned, -2^(DATA_W-1) yields its exact magnitude
    assign neg   = (SIGNED != 0) && disp.value[DATA_W-1];
    assign mag   = neg ? (~disp.value + DATA_W'(1)) : disp.value;
    assign start = (state == IDLE) && disp.load;

    bin2bcd_seq #(
        .DATA_W     (DATA_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .mag   (mag),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (bcd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sign_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (disp.load) begin
                    state  <= CONVERT;
                    sign_q <= neg;
                end
                CONVERT: if (conv_done || !conv_busy) state <= COMMIT;
                COMMIT:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign disp.busy     = (state != IDLE);
    assign disp.overflow = ovf_q;

    always_comb begin
        bcd_ext = '0;
        bcd_ext[BCD_DIGITS*4-1:0] = bcd;
        nd = 1;
        for (int unsigned i = 0; i < BCD_U; i++) begin
            if (bcd[i*4 +: 4] != 4'd0) nd = i + 1;
        end
        need     = sign_q ? nd + 1 : nd;
        next_ovf = (need > DIGITS_U);
        for (int unsigned i = 0; i < DIGITS_U; i++) begin
            next_seg[i] = SEG_BLANK;
            if (next_ovf) begin
                if (i == 0) next_seg[i] = SEG_E;
            end else if (i < nd) begin
                next_seg[i] = bcd_to_seg(bcd_ext[i*4 +: 4]);
            end else if (sign_q && (i == nd)) begin
                next_seg[i] = SEG_MINUS;
            end
        end
    end

    // Whole store loads in the single COMMIT cycle so the display never shows a mix
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DIGITS_U; i++)
                disp_seg[i] <= (i == 0) ? SEG_0 : SEG_BLANK;
            ovf_q <= 1'b0;
        end else if (state == COMMIT) begin
            for (int unsigned i = 0; i < DIGITS_U; i++)
                disp_seg[i] <= next_seg[i];
            ovf_q <= next_ovf;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt     <= '0;
            idx      <= '0;
            disp.an  <= '1;
            disp.seg <= SEG_BLANK;
        end else begin
            if (rcnt == CW'(REFRESH_DIV - 1)) begin
                rcnt <= '0;
                idx  <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
            end else begin
                rcnt <= rcnt + CW'(1);
            end
            disp.an  <= ~(DIGITS'(1) << idx);
            disp.seg <= disp_seg[idx];
        end
    end
endmodule

// File: tb/tb_seg7_signed_display_mux.sv
// Directed bench for seg7_signed_display_mux: four parameter variants share
// one load/value stimulus; each scenario task checks its own expectations.
module tb_seg7_signed_display_mux;
    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
    localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000, S8 = 7'b0000000, S9 = 7'b0010000;
    localparam logic [6:0] SM = 7'b0111111, SB = 7'b1111111, SE = 7'b0000110;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [7:0] value;
    int         total = 0;
    int         bad   = 0;
    int         sel   = 0;
    logic [3:0] v_an;
    logic [6:0] v_seg;
    logic [6:0] cap [4];
    logic [6:0] exp_d [4];
    int         bad_an;

    always #5 clk = ~clk;

    seg7_signed_display_mux_if #(.DATA_W(8), .DIGITS(4)) if_main ();
    seg7_signed_display_mux_if #(.DATA_W(8), .DIGITS(3)) if_d3 ();
    seg7_signed_display_mux_if #(.DATA_W(8), .DIGITS(4)) if_uns ();
    seg7_signed_display_mux_if #(.DATA_W(8), .DIGITS(4)) if_fast ();

    assign if_main.load = load;  assign if_main.value = value;
    assign if_d3.load   = load;  assign if_d3.value   = value;
    assign if_uns.load  = load;  assign if_uns.value  = value;
    assign if_fast.load = load;  assign if_fast.value = value;

    seg7_signed_display_mux #(.DATA_W(8), .DIGITS(4), .SIGNED(1), .REFRESH_DIV(4))
        dut_main (.clk(clk), .rst(rst), .disp(if_main));
    seg7_signed_display_mux #(.DATA_W(8), .DIGITS(3), .SIGNED(1), .REFRESH_DIV(4))
        dut_d3 (.clk(clk), .rst(rst), .disp(if_d3));
    seg7_signed_display_mux #(.DATA_W(8), .DIGITS(4), .SIGNED(0), .REFRESH_DIV(4))
        dut_uns (.clk(clk), .rst(rst), .disp(if_uns));
    seg7_signed_display_mux #(.DATA_W(8), .DIGITS(4), .SIGNED(1), .REFRESH_DIV(1))
        dut_fast (.clk(clk), .rst(rst), .disp(if_fast));

    always_comb begin
        v_an  = if_main.an;
        v_seg = if_main.seg;
        case (sel)
            1: begin v_an = {1'b1, if_d3.an}; v_seg = if_d3.seg; end
            2: begin v_an = if_uns.an;        v_seg = if_uns.seg; end
            3: begin v_an = if_fast.an;       v_seg = if_fast.seg; end
            default: ;
        endcase
    end

    task automatic do_load(input logic [7:0] v);
        @(negedge clk);
        load  = 1'b1;
        value = v;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (if_main.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Record the segment pattern seen under each active anode of the viewed instance
    task automatic scan(input int which);
        sel    = which;
        bad_an = 0;
        for (int k = 0; k < 4; k++) cap[k] = 'x;
        for (int n = 0; n < 24; n++) begin
            @(negedge clk);
            if ($countones(~v_an) != 1) bad_an++;
            else for (int k = 0; k < 4; k++) if (!v_an[k]) cap[k] = v_seg;
        end
    endtask

    task automatic test_reset();
        logic [3:0] ea;
        logic [6:0] es;
        int         d;
        rst = 1'b1; load = 1'b0; value = '0;
        repeat (3) @(negedge clk);
        total += 4;
        if (if_main.an !== 4'hF) begin bad++; $display("FAIL reset_an got=%b want=1111", if_main.an); end
        if (if_main.seg !== SB) begin bad++; $display("FAIL reset_seg got=%b want=%b", if_main.seg, SB); end
        if (if_main.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", if_main.busy); end
        if (if_main.overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", if_main.overflow); end
        rst = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            d  = ((k - 1) / 4) % 4;
            ea = ~(4'b0001 << d);
            es = (d == 0) ? S0 : SB;
            total += 2;
            if (if_main.an !== ea) begin bad++; $display("FAIL refresh_an k=%0d got=%b want=%b", k, if_main.an, ea); end
            if (if_main.seg !== es) begin bad++; $display("FAIL refresh_seg k=%0d got=%b want=%b", k, if_main.seg, es); end
        end
    endtask

    task automatic test_load_56();
        int n;
        do_load(8'd56);
        wait_idle(n);
        total++;
        if (n != 9) begin bad++; $display("FAIL busy_len got=%0d want=9", n); end
        scan(0);
        exp_d = '{S6, S5, SB, SB};
        for (int k = 0; k < 4; k++) begin
            total++;
            if (cap[k] !== exp_d[k]) begin bad++; $display("FAIL v56_d%0d got=%b want=%b", k, cap[k], exp_d[k]); end
        end
        total += 2;
        if (bad_an != 0) begin bad++; $display("FAIL v56_an_onehot got=%0d want=0", bad_an); end
        if (if_main.overflow !== 1'b0) begin bad++; $display("FAIL v56_ovf got=%b want=0", if_main.overflow); end
    endtask

    task automatic test_negative();
        int n;
        do_load(8'hC0);
        wait_idle(n);
        exp_d = '{S4, S6, SM, SB};
        for (int w = 0; w <= 3; w += 3) begin
            scan(w);
            for (int k = 0; k < 4; k++) begin
                total++;
                if (cap[k] !== exp_d[k]) begin bad++; $display("FAIL neg64_i%0d_d%0d got=%b want=%b", w, k, cap[k], exp_d[k]); end
            end
        end
    endtask

    task automatic test_min_value();
        int n;
        do_load(8'h80);
        wait_idle(n);
        scan(0);
        exp_d = '{S8, S2, S1, SM};
        for (int k = 0; k < 4; k++) begin
            total++;
            if (cap[k] !== exp_d[k]) begin bad++; $display("FAIL m128_d%0d got=%b want=%b", k, cap[k], exp_d[k]); end
        end
        scan(1);
        exp_d = '{SE, SB, SB, SB};
        for (int k = 0; k < 3; k++) begin
            total++;
            if (cap[k] !== exp_d[k]) begin bad++; $display("FAIL m128_dig3_d%0d got=%b want=%b", k, cap[k], exp_d[k]); end
        end
        scan(2);
        exp_d = '{S8, S2, S1, SB};
        for (int k = 0; k < 4; k++) begin
            total++;
            if (cap[k] !== exp_d[k]) begin bad++; $display("FAIL u128_d%0d got=%b want=%b", k, cap[k], exp_d[k]); end
        end
        total += 2;
        if (if_d3.overflow !== 1'b1) begin bad++; $display("FAIL m128_dig3_ovf got=%b want=1", if_d3.overflow); end
        if (if_main.overflow !== 1'b0) begin bad++; $display("FAIL m128_ovf got=%b want=0", if_main.overflow); end
    endtask

    task automatic test_drop_and_abort();
        int n;
        do_load(8'd9);
        @(negedge clk);
        load = 1'b1; value = 8'd99;
        @(negedge clk);
        load = 1'b0;
        wait_idle(n);
        total++;
        if (n != 7) begin bad++; $display("FAIL drop_busy_rest got=%0d want=7", n); end
        scan(0);
        exp_d = '{S9, SB, SB, SB};
        for (int k = 0; k < 4; k++) begin
            total++;
            if (cap[k] !== exp_d[k]) begin bad++; $display("FAIL drop_d%0d got=%b want=%b", k, cap[k], exp_d[k]); end
        end
        total++;
        if (if_d3.overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b want=0", if_d3.overflow); end
        do_load(8'd77);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        total += 2;
        if (if_main.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", if_main.busy); end
        if (if_main.an !== 4'hF) begin bad++; $display("FAIL abort_an got=%b want=1111", if_main.an); end
        @(negedge clk);
        rst = 1'b0;
        scan(0);
        exp_d = '{S0, SB, SB, SB};
        for (int k = 0; k < 4; k++) begin
            total++;
            if (cap[k] !== exp_d[k]) begin bad++; $display("FAIL abort_d%0d got=%b want=%b", k, cap[k], exp_d[k]); end
        end
    endtask

    task automatic test_unsigned_fast();
        int         n;
        logic [3:0] prev;
        do_load(8'hFF);
        wait_idle(n);
        scan(2);
        exp_d = '{S5, S5, S2, SB};
        for (int k = 0; k < 4; k++) begin
            total++;
            if (cap[k] !== exp_d[k]) begin bad++; $display("FAIL u255_d%0d got=%b want=%b", k, cap[k], exp_d[k]); end
        end
        scan(3);
        exp_d = '{S1, SM, SB, SB};
        for (int k = 0; k < 4; k++) begin
            total++;
            if (cap[k] !== exp_d[k]) begin bad++; $display("FAIL fast_m1_d%0d got=%b want=%b", k, cap[k], exp_d[k]); end
        end
        @(negedge clk);
        prev = if_fast.an;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            total++;
            if (if_fast.an !== {prev[2:0], prev[3]} || $countones(~if_fast.an) != 1) begin
                bad++;
                $display("FAIL fast_an k=%0d got=%b want=%b", k, if_fast.an, {prev[2:0], prev[3]});
            end
            prev = if_fast.an;
        end
    endtask

    task automatic test_back_to_back();
        int n1;
        int n2;
        do_load(8'd0);
        wait_idle(n1);
        do_load(8'd127);
        wait_idle(n2);
        total += 2;
        if (n1 != 9) begin bad++; $display("FAIL b2b_busy1 got=%0d want=9", n1); end
        if (n2 != 9) begin bad++; $display("FAIL b2b_busy2 got=%0d want=9", n2); end
        scan(1);
        exp_d = '{S7, S2, S1, SB};
        for (int k = 0; k < 3; k++) begin
            total++;
            if (cap[k] !== exp_d[k]) begin bad++; $display("FAIL v127_dig3_d%0d got=%b want=%b", k, cap[k], exp_d[k]); end
        end
        total++;
        if (if_d3.overflow !== 1'b0) begin bad++; $display("FAIL v127_dig3_ovf got=%b want=0", if_d3.overflow); end
    endtask

    initial begin
        test_reset();
        test_load_56();
        test_negative();
        test_min_value();
        test_drop_and_abort();
        test_unsigned_fast();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
